// File: rtl/alu_sequencer.sv
// Multicycle sequencer for an external ALU: owns the 8x16 register file plus A, G, IR and Z,
// and walks each instruction through operand fetch (T1), evaluate (T2) and write-back (T3).
module alu_sequencer (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Run,
   input  logic [8:0]  Instr,
   input  logic        Ld_en,
   input  logic [2:0]  Ld_addr,
   input  logic [15:0] Ld_data,
   input  logic [2:0]  Rd_addr,
   input  logic [15:0] Saida_ALU,
   input  logic        z_flag,
   output logic [15:0] BusWires,
   output logic [15:0] A,
   output logic [1:0]  ALU,
   output logic        shift_in,
   output logic [15:0] shift_out,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic        Z,
   output logic [15:0] Rd_data
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_ERR} state_t;

   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;

   state_t      state_q, state_d;
   logic [8:0]  ir_q, ir_d;
   logic [15:0] a_q, a_d;
   logic [15:0] g_q, g_d;
   logic        z_q, z_d;
   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];

   logic [2:0]  op, rx, ry;
   logic [15:0] ry_val;
   logic        is_shift;

   assign op       = ir_q[8:6];
   assign rx       = ir_q[5:3];
   assign ry       = ir_q[2:0];
   assign ry_val   = regs_q[ry];
   assign is_shift = (op == OP_SHL) || (op == OP_SHR);

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      a_d       = a_q;
      g_d       = g_q;
      z_d       = z_q;
      for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
      BusWires  = '0;
      ALU       = 2'b00;
      shift_in  = 1'b0;
      shift_out = '0;

      case (state_q)
         S_IDLE: begin
            // External loads land in the same edge as an accept, so T1 sees the new value.
            if (Ld_en) regs_d[Ld_addr] = Ld_data;
            if (Run) begin
               ir_d    = Instr;
               state_d = (Instr[8:6] > OP_CMP) ? S_ERR : S_T1;
            end
         end
         S_T1: begin
            BusWires = regs_q[rx];
            a_d      = regs_q[rx];
            state_d  = S_T2;
         end
         S_T2: begin
            BusWires = ry_val;
            g_d      = Saida_ALU;
            state_d  = S_T3;
            case (op)
               OP_SUB, OP_CMP: ALU = 2'b01;
               OP_AND:         ALU = 2'b10;
               OP_SHL: begin
                  shift_in  = 1'b1;
                  shift_out = a_q << ry_val[3:0];
               end
               OP_SHR: begin
                  shift_in  = 1'b1;
                  shift_out = a_q >> ry_val[3:0];
               end
               default:        ALU = 2'b00;
            endcase
            if (!is_shift) z_d = z_flag;
         end
         S_T3: begin
            BusWires = g_q;
            if (op != OP_CMP) regs_d[rx] = g_q;
            state_d  = S_IDLE;
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         g_q     <= g_d;
         z_q     <= z_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_regfile
         always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) regs_q[gi] <= '0;
            else         regs_q[gi] <= regs_d[gi];
         end
      end
   endgenerate

   assign A       = a_q;
   assign Z       = z_q;
   assign Busy    = (state_q != S_IDLE);
   assign Done    = (state_q == S_T3) || (state_q == S_ERR);
   assign Err     = (state_q == S_ERR);
   assign Rd_data = regs_q[Rd_addr];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multicycle control-and-register block that drives the processor's ALU from the other side of its interface. It accepts one ALU-class instruction per Run handshake, owns the 8×16 register file and the A and G registers, and sequences operand fetch, ALU/shift evaluation and write-back over three states. It also captures the zero flag into a status register, Z.

## Interface
- No parameters; data width is fixed at 16, register count at 8.
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  instruction request; sampled only in IDLE.
- Instr  in  9  {op[2:0], rx[2:0], ry[2:0]}. Op codes:
  - 000 add, 001 sub, 010 and
  - 011 shl, 100 shr
  - 101 cmp
  - 110 and 111 illegal
- Ld_en, Ld_addr[2:0], Ld_data[15:0]  in  1/3/16  external register write port.
- Rd_addr  in  3  debug read select.
- Saida_ALU  in  16  ALU result.
- z_flag  in  1  ALU zero indication.
- BusWires  out  16  bus value presented to the ALU.
- A  out  16  A register, driven continuously.
- ALU  out  2  ALU select: 00 add, 01 sub, 10 and.
- shift_in  out  1  ALU result override enable.
- shift_out  out  16  shifter result.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle illegal-op pulse, coincident with Done.
- Z  out  1  registered zero status.
- Rd_data  out  16  combinational R[Rd_addr].

## Operation
- States: IDLE, T1, T2, T3, ERR.
- IDLE:
  - Run=1 latches Instr into IR.
  - Legal op → T1; illegal op → ERR.
  - BusWires=0, ALU=00, shift_in=0.
- T1: BusWires=R[rx]; A ← R[rx] at the edge; → T2.
- T2: BusWires=R[ry]; G ← Saida_ALU at the edge; → T3.
  - add: ALU=00. sub and cmp: ALU=01. and: ALU=10.
  - Z ← z_flag for add, sub, and, cmp. Z is unchanged for shifts.
  - shl/shr: shift_in=1, ALU=00.
    - shift_out = A << R[ry][3:0] for shl; A >> R[ry][3:0] for shr (logical, zero fill).
    - Shift amount 0 passes A through.
  - shift_out=0 whenever shift_in=0.
- T3: BusWires=G; Done=1; → IDLE.
  - R[rx] ← G at the edge for every op except cmp, which writes nothing.
- ERR: Done=1, Err=1; no register or Z change; → IDLE.
- Register file:
  - Ld_en applies only in IDLE: R[Ld_addr] ← Ld_data.
  - Ld_en while Busy is dropped; there is no queueing.
  - Ld_en and Run in the same IDLE cycle: the load and the accept both happen, and T1 sees the loaded value.
- rx==ry is legal. T2 reads the pre-write value, since write-back occurs only in T3.
- Arithmetic is 16-bit modulo 2^16; carry and borrow are discarded.

## Timing
- Reset (asynchronous assert, synchronous release on Clock):
  - State=IDLE.
  - R0–R7, A, G and IR = 0.
  - Z=0, Done=0, Err=0, Busy=0.
  - BusWires=0, ALU=00, shift_in=0, shift_out=0.
- Reset asserted mid-instruction aborts it immediately. No write-back occurs and Done is not pulsed.
- Legal instruction: Run accepted at edge k; Busy high in cycles k+1..k+3; Done high in cycle k+3; result visible on Rd_data from cycle k+4.
- Illegal instruction: Done and Err high in cycle k+1; Busy high in cycle k+1.
- Back-to-back: Run may be reasserted in the first IDLE cycle after Done, giving a 4-cycle throughput.
- Run while Busy is ignored and not queued.
- All outputs other than Rd_data, BusWires, ALU, shift_in and shift_out are registered or state-decoded with no input paths. Those five are decoded from state, IR and registers.

## Test plan
- Add:
  - Stimulus: load R1=0x0005, R2=0x0003; Run with add r1,r2.
  - Response: Done exactly 3 cycles after accept; R1=0x0008; Z=0; BusWires sequence 0x0005, 0x0003, 0x0008.
- Sub with zero:
  - Stimulus: R3=R4=0x1234; sub r3,r4.
  - Response: R3=0x0000, Z=1. Then cmp r3,r3 gives Z=1 and no write (R3 stays 0).
- Shifts:
  - Stimulus: R5=0x8001, R6=0x0004; shl r5,r6.
  - Response: shift_in=1 in T2 only; R5=0x0010; Z unchanged.
  - Then shr with R6=0 leaves R5 unchanged.
- Illegal op and dropped inputs:
  - Instr op=110: Done=Err=1 in the next cycle; no register or Z change.
  - Ld_en during Busy is dropped; Run during Busy is ignored.
- Reset mid-operation:
  - Stimulus: assert Resetn=0 in T2 of add r0,r1.
  - Response: all outputs at reset values immediately; no Done; R0=0 after release.
- Wrap-around and back-to-back:
  - Stimulus: R7=0xFFFF, R0=0x0001; add r7,r0, then Run in the first IDLE cycle with add r7,r7.
  - Response: R7=0x0000 with Z=1, then R7=0x0000 with Z=1; second Done 4 cycles after the first.
